// File: rtl/prog_run_sequencer.sv
// prog_run_sequencer
// Bring-up sequencer for the single-cycle core. It fills instruction memory
// from a valid/ready word stream while the core is held in reset, runs the
// core until it fetches the halt word or the cycle budget is used up, and
// then streams the 16 architectural registers out over a valid/ready port.
module prog_run_sequencer #(
   parameter int          IMEM_AW    = 10,
   parameter int          MAX_CYCLES = 1024,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
   parameter int          CNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   // load stream
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [31:0]        load_data,
   input  logic               load_last,
   // instruction memory write port
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   // core control
   output logic               cpu_reset,
   output logic               cpu_run,
   input  logic [31:0]        cpu_instruction,
   // register file debug read port
   output logic [3:0]         reg_rd_addr,
   input  logic [15:0]        reg_rd_data,
   // register dump stream
   output logic               dump_valid,
   input  logic               dump_ready,
   output logic [15:0]        dump_data,
   output logic               dump_last,
   // status
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [CNT_W-1:0]   cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DUMP
   } state_e;

   // Final load address: a handshake here ends the load even without load_last.
   localparam logic [IMEM_AW-1:0] PTR_LAST    = '1;
   // Saturation value of the run cycle counter.
   localparam logic [CNT_W-1:0]   CNT_SAT     = '1;
   // Counter value seen during the last cycle the budget allows.
   localparam logic [CNT_W-1:0]   BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
   // Index of the last architectural register streamed out.
   localparam logic [3:0]         IDX_LAST    = 4'd15;

   state_e             state_q;
   logic [IMEM_AW-1:0] ptr_q;
   logic [CNT_W-1:0]   cycle_count_q;
   logic [CNT_W-1:0]   cycle_count_d;
   logic [3:0]         idx_q;
   logic               timeout_q;
   logic               done_q;
   logic               busy_q;
   logic               load_ready_q;
   logic               cpu_reset_q;
   logic               run_q;
   logic               dump_valid_q;
   logic               dump_last_q;

   logic               load_hs;
   logic               load_end;
   logic               halt_seen;
   logic               budget_hit;
   logic               dump_hs;

   // Handshake and run-termination decodes shared by the FSM and the outputs.
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path, so no latch can be inferred.
      load_hs    = load_valid & load_ready_q;
      load_end   = load_last | (ptr_q == PTR_LAST);
      halt_seen  = run_q & (cpu_instruction == HALT_WORD);
      budget_hit = (cycle_count_q == BUDGET_LAST);
      dump_hs    = dump_valid_q & dump_ready;
      if (cycle_count_q == CNT_SAT) begin
         cycle_count_d = cycle_count_q;
      end else begin
         cycle_count_d = cycle_count_q + 1'b1;
      end
   end

   // Sequencer FSM: state, pointers, counters and every registered output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         cycle_count_q <= '0;
         idx_q         <= '0;
         timeout_q     <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         load_ready_q  <= 1'b0;
         cpu_reset_q   <= 1'b1;
         run_q         <= 1'b0;
         dump_valid_q  <= 1'b0;
         dump_last_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_LOAD;
                  ptr_q         <= '0;
                  cycle_count_q <= '0;
                  timeout_q     <= 1'b0;
                  busy_q        <= 1'b1;
                  load_ready_q  <= 1'b1;
               end
            end

            S_LOAD: begin
               if (load_hs) begin
                  // Hold the pointer at the top address so it never wraps to 0.
                  if (ptr_q != PTR_LAST) begin
                     ptr_q <= ptr_q + 1'b1;
                  end
                  if (load_end) begin
                     state_q      <= S_RUN;
                     load_ready_q <= 1'b0;
                     cpu_reset_q  <= 1'b0;
                     run_q        <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               // The halt word is never executed and does not count as a run cycle;
               // it also takes priority over an expiring budget.
               if (halt_seen) begin
                  state_q      <= S_DUMP;
                  run_q        <= 1'b0;
                  idx_q        <= '0;
                  dump_valid_q <= 1'b1;
                  dump_last_q  <= 1'b0;
               end else begin
                  cycle_count_q <= cycle_count_d;
                  if (budget_hit) begin
                     state_q      <= S_DUMP;
                     timeout_q    <= 1'b1;
                     run_q        <= 1'b0;
                     idx_q        <= '0;
                     dump_valid_q <= 1'b1;
                     dump_last_q  <= 1'b0;
                  end
               end
            end

            S_DUMP: begin
               if (dump_hs) begin
                  if (idx_q == IDX_LAST) begin
                     state_q      <= S_IDLE;
                     idx_q        <= '0;
                     dump_valid_q <= 1'b0;
                     dump_last_q  <= 1'b0;
                     done_q       <= 1'b1;
                     busy_q       <= 1'b0;
                     cpu_reset_q  <= 1'b1;
                  end else begin
                     idx_q       <= idx_q + 1'b1;
                     dump_last_q <= (idx_q == (IDX_LAST - 4'd1));
                  end
               end
            end

            default: begin
               state_q      <= S_IDLE;
               busy_q       <= 1'b0;
               load_ready_q <= 1'b0;
               cpu_reset_q  <= 1'b1;
               run_q        <= 1'b0;
               dump_valid_q <= 1'b0;
               dump_last_q  <= 1'b0;
            end
         endcase
      end
   end

   // Load path: the write strobe is the live handshake, address is the load pointer.
   assign load_ready = load_ready_q;
   assign imem_we    = load_hs;
   assign imem_addr  = ptr_q;
   assign imem_wdata = load_data;

   // Core control: the clock enable drops in the same cycle the halt word is fetched.
   assign cpu_reset  = cpu_reset_q;
   assign cpu_run    = run_q & ~halt_seen;

   // Dump path: the register file read is asynchronous, so data follows the index.
   assign reg_rd_addr = idx_q;
   assign dump_valid  = dump_valid_q;
   assign dump_data   = reg_rd_data;
   assign dump_last   = dump_last_q;

   // Status.
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Directed bench for prog_run_sequencer. A tiny behavioural core (add, jump,
// everything else falls through) executes from a bench-side copy of
// instruction memory that is filled only through the DUT's write port.
module tb_prog_run_sequencer;

   localparam int          IMEM_AW    = 10;
   localparam int          MAX_CYCLES = 20;
   localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
   localparam int          CNT_W      = 16;
   localparam int          DEPTH      = 1 << IMEM_AW;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic               load_valid;
   logic               load_ready;
   logic [31:0]        load_data;
   logic               load_last;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;
   logic               cpu_reset;
   logic               cpu_run;
   logic [31:0]        cpu_instruction;
   logic [3:0]         reg_rd_addr;
   logic [15:0]        reg_rd_data;
   logic               dump_valid;
   logic               dump_ready;
   logic [15:0]        dump_data;
   logic               dump_last;
   logic               busy;
   logic               done;
   logic               timeout;
   logic [CNT_W-1:0]   cycle_count;

   prog_run_sequencer #(
      .IMEM_AW   (IMEM_AW),
      .MAX_CYCLES(MAX_CYCLES),
      .HALT_WORD (HALT_WORD),
      .CNT_W     (CNT_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .load_data      (load_data),
      .load_last      (load_last),
      .imem_we        (imem_we),
      .imem_addr      (imem_addr),
      .imem_wdata     (imem_wdata),
      .cpu_reset      (cpu_reset),
      .cpu_run        (cpu_run),
      .cpu_instruction(cpu_instruction),
      .reg_rd_addr    (reg_rd_addr),
      .reg_rd_data    (reg_rd_data),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_data      (dump_data),
      .dump_last      (dump_last),
      .busy           (busy),
      .done           (done),
      .timeout        (timeout),
      .cycle_count    (cycle_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- bench-side memory, register file and core ----------------
   logic [31:0]        imem_model [DEPTH];
   logic [15:0]        regs [16];
   logic [IMEM_AW-1:0] pc;

   assign cpu_instruction = imem_model[pc];
   assign reg_rd_data     = regs[reg_rd_addr];

   int we_count   = 0;
   int we_base    = 0;
   int done_count = 0;
   int done_base  = 0;

   // Capture memory writes and done pulses between clock edges.
   always @(negedge clock) begin
      if (imem_we) begin
         check("imem_addr_seq", 32'(imem_addr), we_count - we_base);
         imem_model[imem_addr] = imem_wdata;
         we_count = we_count + 1;
      end
      if (done) done_count = done_count + 1;
   end

   // Minimal core: add rd,rs,rt and j target; anything else just advances the PC.
   always @(posedge clock) begin
      if (reset) begin
         pc <= '0;
         for (int i = 0; i < 16; i++) regs[i] <= 16'h1000 + 16'(i) * 16'h0101;
      end else if (cpu_reset) begin
         pc <= '0;
      end else if (cpu_run) begin
         if (cpu_instruction[31:26] == 6'd2) begin
            pc <= cpu_instruction[IMEM_AW-1:0];
         end else begin
            if (cpu_instruction[31:26] == 6'd0 && cpu_instruction[5:0] == 6'h20)
               regs[cpu_instruction[14:11]] <= regs[cpu_instruction[24:21]] + regs[cpu_instruction[19:16]];
            pc <= pc + 1'b1;
         end
      end
   end

   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      return {6'd0, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   // Register values after the 3-add program, computed by hand.
   logic [15:0] exp_regs [16];
   int          run_cycles;

   // ---------------- stimulus helpers ----------------
   task automatic do_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the handshake edge.
   task automatic send_word(input logic [31:0] data, input logic last, input logic gap);
      bit ok = 0;
      if (gap) begin
         load_valid = 1'b0;
         @(posedge clock); #1;
      end
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (load_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("load_handshake_timeout", 0, 1);
      @(posedge clock); #1;
   endtask

   // Sample RUN cycles until the dump starts; ends on the negedge where dump_valid is seen.
   task automatic run_until_dump();
      bit seen = 0;
      run_cycles = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (dump_valid) begin
            seen = 1;
            break;
         end
         if (cpu_run) run_cycles++;
         else if (cpu_instruction == HALT_WORD && !cpu_reset) check("halt_gates_run", 32'(cpu_run), 0);
      end
      if (!seen) check("dump_start_timeout", 0, 1);
   endtask

   // Drain all 16 registers; optionally stall 5 cycles at stall_idx.
   task automatic dump_all(input int stall_idx);
      done_base = done_count;
      for (int i = 0; i < 16; i++) begin
         check("dump_valid", 32'(dump_valid), 1);
         check("dump_addr", 32'(reg_rd_addr), i);
         check("dump_data", 32'(dump_data), 32'(exp_regs[i]));
         check("dump_last", 32'(dump_last), (i == 15) ? 1 : 0);
         if (i == stall_idx) begin
            dump_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clock);
               check("stall_addr", 32'(reg_rd_addr), i);
               check("stall_data", 32'(dump_data), 32'(exp_regs[i]));
               check("stall_valid", 32'(dump_valid), 1);
            end
         end
         dump_ready = 1'b1;
         @(posedge clock);
         @(negedge clock);
      end
      dump_ready = 1'b0;
      check("done_pulse", 32'(done), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_cpu_reset", 32'(cpu_reset), 1);
      check("idle_dump_valid", 32'(dump_valid), 0);
      @(negedge clock);
      check("done_one_cycle", 32'(done), 0);
      check("done_count", done_count - done_base, 1);
      @(posedge clock); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 16; i++) exp_regs[i] = 16'h1000 + 16'(i) * 16'h0101;
      exp_regs[1] = 16'h2505;
      exp_regs[4] = 16'h4A0A;
      exp_regs[5] = 16'h5C0C;

      reset      = 1'b1;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      dump_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_load_ready", 32'(load_ready), 0);
      check("rst_cpu_reset", 32'(cpu_reset), 1);
      check("rst_cpu_run", 32'(cpu_run), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_dump_valid", 32'(dump_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_cycle_count", 32'(cycle_count), 0);
      check("rst_imem_addr", 32'(imem_addr), 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Abort a load after three words with an asynchronous reset.
      we_base = we_count;
      do_start();
      check("load_busy", 32'(busy), 1);
      check("load_ready_on", 32'(load_ready), 1);
      for (int k = 0; k < 3; k++) send_word(32'hDEAD_0000 + k, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("abort_load_ready", 32'(load_ready), 0);
      check("abort_cpu_reset", 32'(cpu_reset), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_imem_addr", 32'(imem_addr), 0);
      repeat (2) @(posedge clock);
      #1;
      reset      = 1'b0;
      load_valid = 1'b0;
      @(negedge clock);
      check("abort_write_count", we_count - we_base, 3);
      @(posedge clock); #1;

      // Three adds then the halt word, with valid toggling between words.
      we_base = we_count;
      do_start();
      send_word(enc_add(5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
      send_word(enc_add(5'd4, 5'd1, 5'd1), 1'b0, 1'b1);
      send_word(enc_add(5'd5, 5'd4, 5'd2), 1'b0, 1'b1);
      send_word(HALT_WORD, 1'b1, 1'b1);
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("run_entry_cpu_reset", 32'(cpu_reset), 0);
      check("run_entry_load_ready", 32'(load_ready), 0);
      check("run_entry_cpu_run", 32'(cpu_run), 1);
      check("prog_write_count", we_count - we_base, 4);
      run_until_dump();
      check("halt_run_cycles", run_cycles, 3);
      check("halt_cycle_count", 32'(cycle_count), 3);
      check("halt_timeout", 32'(timeout), 0);
      check("dump_cpu_reset", 32'(cpu_reset), 0);
      dump_all(7);

      // Jump-to-self program: runs out the cycle budget.
      we_base = we_count;
      do_start();
      send_word({6'd2, 26'd0}, 1'b1, 1'b0);
      load_valid = 1'b0;
      load_last  = 1'b0;
      run_until_dump();
      check("budget_run_cycles", run_cycles, MAX_CYCLES);
      check("budget_cycle_count", 32'(cycle_count), MAX_CYCLES);
      check("budget_timeout", 32'(timeout), 1);
      dump_all(-1);
      check("timeout_sticky", 32'(timeout), 1);

      // Full-depth load without load_last; timeout and counter clear on start.
      we_base = we_count;
      do_start();
      check("start_clears_timeout", 32'(timeout), 0);
      check("start_clears_count", 32'(cycle_count), 0);
      for (int k = 0; k < DEPTH; k++) send_word((k == 0) ? HALT_WORD : (32'hA5A5_0000 + k), 1'b0, 1'b0);
      check("full_cpu_reset", 32'(cpu_reset), 0);
      check("full_load_ready", 32'(load_ready), 0);
      check("full_imem_addr", 32'(imem_addr), DEPTH - 1);
      run_until_dump();
      load_valid = 1'b0;
      check("full_write_count", we_count - we_base, DEPTH);
      check("full_no_wrap", imem_model[0], HALT_WORD);
      check("full_last_word", imem_model[DEPTH-1], 32'hA5A5_0000 + DEPTH - 1);
      check("full_run_cycles", run_cycles, 0);
      check("full_cycle_count", 32'(cycle_count), 0);
      check("full_timeout", 32'(timeout), 0);
      dump_all(-1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
